// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// General-purpose register bank for the MIPS decode stage. It holds SIZE_REG
// registers of BITS_SIZE bits; register 0 always reads as zero. It is written
// by the write-back stage and read by decode.
//
// Ports:
//   i_clk          system clock; all state updates on the rising edge
//   i_reset        synchronous, active-high; clears every register and the
//                  debug output register
//   i_enable       pipeline step enable; gates writes only, not reads
//   i_reg_write    write-back write enable
//   i_write_addr   destination register (rd, rt or 31 for JAL)
//   i_write_data   write-back data
//   i_read_addr_a  rs address
//   i_read_addr_b  rt address
//   o_read_data_a  rs operand (combinational, with same-cycle write bypass)
//   o_read_data_b  rt operand (combinational, with same-cycle write bypass)
//   i_debug_addr   debug unit register select
//   o_debug_data   registered debug read data (stored contents, no bypass)
// -----------------------------------------------------------------------------
module register_file #(
    parameter int BITS_REGS = 5,
    parameter int BITS_SIZE = 32,
    parameter int SIZE_REG  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_reg_write,
    input  logic [BITS_REGS-1:0] i_write_addr,
    input  logic [BITS_SIZE-1:0] i_write_data,
    input  logic [BITS_REGS-1:0] i_read_addr_a,
    input  logic [BITS_REGS-1:0] i_read_addr_b,
    output logic [BITS_SIZE-1:0] o_read_data_a,
    output logic [BITS_SIZE-1:0] o_read_data_b,
    input  logic [BITS_REGS-1:0] i_debug_addr,
    output logic [BITS_SIZE-1:0] o_debug_data
);

    // Register array, kept in flops so both read ports are combinational.
    logic [BITS_SIZE-1:0] regs_q [SIZE_REG];
    logic [BITS_SIZE-1:0] regs_d [SIZE_REG];

    logic [BITS_SIZE-1:0] debug_q;
    logic [BITS_SIZE-1:0] debug_d;

    // A write only takes effect when enabled and not aimed at r0. The same
    // term qualifies the read bypass, so a discarded write is never forwarded.
    logic wr_en;
    assign wr_en = i_reg_write && i_enable && (i_write_addr != '0);

    // Next-state for the array. r0 is forced to zero so it never holds data.
    always_comb begin
        regs_d[0] = '0;
        for (int i = 1; i < SIZE_REG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (i_write_addr == BITS_REGS'(i))) begin
                regs_d[i] = i_write_data;
            end
        end
    end

    // Debug samples stored contents only; a write on the same edge is not
    // visible until the following edge.
    always_comb begin
        debug_d = regs_q[i_debug_addr];
    end

    // Reset wins over a simultaneous write: that write is lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < SIZE_REG; i++) begin
                regs_q[i] <= '0;
            end
            debug_q <= '0;
        end else begin
            for (int i = 0; i < SIZE_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            debug_q <= debug_d;
        end
    end

    // Read ports: r0 reads zero, a matching qualified write is forwarded
    // (write-before-read), otherwise the stored value is returned. The bypass
    // does not look at i_reset, so it still forwards while reset is asserted.
    always_comb begin
        if (i_read_addr_a == '0) begin
            o_read_data_a = '0;
        end else if (wr_en && (i_write_addr == i_read_addr_a)) begin
            o_read_data_a = i_write_data;
        end else begin
            o_read_data_a = regs_q[i_read_addr_a];
        end
    end

    always_comb begin
        if (i_read_addr_b == '0) begin
            o_read_data_b = '0;
        end else if (wr_en && (i_write_addr == i_read_addr_b)) begin
            o_read_data_b = i_write_data;
        end else begin
            o_read_data_b = regs_q[i_read_addr_b];
        end
    end

    assign o_debug_data = debug_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic [4:0]  debug_addr;
    logic [31:0] debug_data;

    int n_checks = 0;
    int n_fails  = 0;

    register_file #(
        .BITS_REGS(5),
        .BITS_SIZE(32),
        .SIZE_REG (32)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_reg_write  (reg_write),
        .i_write_addr (write_addr),
        .i_write_data (write_data),
        .i_read_addr_a(read_addr_a),
        .i_read_addr_b(read_addr_b),
        .o_read_data_a(read_data_a),
        .o_read_data_b(read_data_b),
        .i_debug_addr (debug_addr),
        .o_debug_data (debug_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  dbg;
        logic [31:0] exp_a;    // read port A before the edge
        logic [31:0] exp_b;    // read port B before the edge
        logic [31:0] exp_dbg;  // debug output after the edge
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            we    en    wa     wd            ra     rb     dbg    exp_a         exp_b         exp_dbg
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'h0,        5'd0,  5'd0,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b1, 5'd31, 32'h00000048, 5'd5,  5'd31, 5'd31, 32'hDEADBEEF, 32'h48,       32'h0};
        vecs[5]  = '{1'b1, 1'b0, 5'd31, 32'h00000099, 5'd31, 5'd31, 5'd31, 32'h48,       32'h48,       32'h48};
        vecs[6]  = '{1'b0, 1'b1, 5'd0,  32'h0,        5'd31, 5'd5,  5'd0,  32'h48,       32'hDEADBEEF, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 5'd10, 32'h00000055, 5'd10, 5'd1,  5'd10, 32'h55,       32'h0,        32'h0};
        vecs[8]  = '{1'b1, 1'b1, 5'd9,  32'h0000CAFE, 5'd9,  5'd9,  5'd10, 32'hCAFE,     32'hCAFE,     32'h55};
        vecs[9]  = '{1'b1, 1'b1, 5'd9,  32'h0000BEEF, 5'd10, 5'd9,  5'd9,  32'h55,       32'hBEEF,     32'hCAFE};
        vecs[10] = '{1'b1, 1'b1, 5'd7,  32'h00001111, 5'd7,  5'd9,  5'd7,  32'h1111,     32'hBEEF,     32'h0};
        vecs[11] = '{1'b0, 1'b1, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'h1111,     32'h1111,     32'h1111};
        vecs[12] = '{1'b1, 1'b0, 5'd3,  32'h0000AAAA, 5'd3,  5'd3,  5'd3,  32'h0,        32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b1, 5'd0,  32'h0,        5'd3,  5'd3,  5'd3,  32'h0,        32'h0,        32'h0};

        reset       = 1'b1;
        enable      = 1'b0;
        reg_write   = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        read_addr_a = '0;
        read_addr_b = '0;
        debug_addr  = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Every register reads zero after reset on both ports.
        check("reset_debug", debug_data, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_addr_a = 5'(i);
            read_addr_b = 5'(31 - i);
            #1;
            check($sformatf("reset_a_r%0d", i), read_data_a, 32'h0);
            check($sformatf("reset_b_r%0d", 31 - i), read_data_b, 32'h0);
        end
        $display("reset: all 32 registers checked on ports A and B");

        // Table-driven vectors: comb reads before the edge, debug after it.
        for (int v = 0; v < NVEC; v++) begin
            reg_write   = vecs[v].we;
            enable      = vecs[v].en;
            write_addr  = vecs[v].wa;
            write_data  = vecs[v].wd;
            read_addr_a = vecs[v].ra;
            read_addr_b = vecs[v].rb;
            debug_addr  = vecs[v].dbg;
            #2;
            check($sformatf("vec%0d_read_a", v), read_data_a, vecs[v].exp_a);
            check($sformatf("vec%0d_read_b", v), read_data_b, vecs[v].exp_b);
            tick();
            check($sformatf("vec%0d_debug", v), debug_data, vecs[v].exp_dbg);
            $display("vec%0d: we=%0b en=%0b wa=%0d wd=0x%08h ra=%0d rb=%0d dbg=%0d -> a=0x%08h b=0x%08h dbg=0x%08h",
                     v, vecs[v].we, vecs[v].en, vecs[v].wa, vecs[v].wd, vecs[v].ra,
                     vecs[v].rb, vecs[v].dbg, read_data_a, read_data_b, debug_data);
        end

        // Reset coinciding with a write to r7 (r7 holds 0x1111, r9 holds 0xBEEF).
        reset       = 1'b1;
        reg_write   = 1'b1;
        enable      = 1'b1;
        write_addr  = 5'd7;
        write_data  = 32'h2222;
        read_addr_a = 5'd7;
        read_addr_b = 5'd9;
        debug_addr  = 5'd7;
        #2;
        check("rst_wr_bypass_a", read_data_a, 32'h2222);
        check("rst_wr_stored_b", read_data_b, 32'hBEEF);
        tick();
        reset     = 1'b0;
        reg_write = 1'b0;
        #1;
        check("rst_wr_debug", debug_data, 32'h0);
        check("rst_wr_r7_after", read_data_a, 32'h0);
        check("rst_wr_r9_after", read_data_b, 32'h0);
        tick();
        check("rst_wr_debug_r7_next", debug_data, 32'h0);
        $display("reset+write r7: a=0x%08h b=0x%08h dbg=0x%08h", read_data_a, read_data_b, debug_data);

        // Write after reset commits normally again.
        reg_write  = 1'b1;
        write_addr = 5'd7;
        write_data = 32'h3333;
        tick();
        reg_write = 1'b0;
        #1;
        check("post_rst_write_r7", read_data_a, 32'h3333);
        tick();
        check("post_rst_debug_r7", debug_data, 32'h3333);
        $display("post-reset write r7: a=0x%08h dbg=0x%08h", read_data_a, debug_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
